// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter for two requesters that expands each transaction into the RAM's two-word command protocol.
// Defining RAM_ARB_TIMEOUT_EN adds a read timeout: after TIMEOUT_CYC wait cycles the read ends with rsp_err set.
//
// state | meaning
// IDLE  | arbitrate; req_ready asserted to the winner
// WADDR | write-address command on ram_din
// WDATA | write-data command on ram_din
// RADDR | read-address command on ram_din
// RCMD  | read-data command on ram_din
// RWAIT | waiting for ram_tx_valid (or timeout)
// RSP   | rsp_valid pulse to the owning requester
module ram_cmd_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_we,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          req_ready,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [ADDR_W+1:0]   ram_din,
   output logic                ram_rx_valid,
   input  logic [DATA_W-1:0]   ram_dout,
   input  logic                ram_tx_valid
);

   if (ADDR_W != DATA_W) begin : g_width_chk
      $error("ram_cmd_arbiter: ADDR_W must equal DATA_W");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_chk
      $error("ram_cmd_arbiter: TIMEOUT_CYC must be 1..255");
   end

   typedef enum logic [2:0] {IDLE, WADDR, WDATA, RADDR, RCMD, RWAIT, RSP} state_t;

   state_t            state;
   logic              last_gnt;
   logic              own;
   logic [DATA_W-1:0] cur_wdata;
   logic              gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef RAM_ARB_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0] wait_cnt;
`endif

   always_comb begin
      gnt = 1'b0;
      if (req_valid == 2'b11) gnt = ~last_gnt;
      else if (req_valid[1])  gnt = 1'b1;
      sel_we    = gnt ? req_we[1] : req_we[0];
      sel_addr  = gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      sel_wdata = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      req_ready = 2'b00;
      // gated by rst so the acceptance pulse is also silent while reset is held
      if (state == IDLE && !rst && req_valid != 2'b00) req_ready = gnt ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_gnt     <= 1'b1;
         own          <= 1'b0;
         cur_wdata    <= '0;
         rsp_valid    <= 2'b00;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
         wait_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid != 2'b00) begin
                  own          <= gnt;
                  last_gnt     <= gnt;
                  cur_wdata    <= sel_wdata;
                  ram_din      <= {(sel_we ? 2'b00 : 2'b10), sel_addr};
                  ram_rx_valid <= 1'b1;
                  state        <= sel_we ? WADDR : RADDR;
               end
            end
            WADDR: begin
               ram_din <= {2'b01, cur_wdata};
               state   <= WDATA;
            end
            WDATA: begin
               ram_din      <= '0;
               ram_rx_valid <= 1'b0;
               rsp_valid    <= {own, ~own};
               rsp_rdata    <= '0;
               rsp_err      <= 1'b0;
               state        <= RSP;
            end
            RADDR: begin
               ram_din <= {2'b11, {ADDR_W{1'b0}}};
               state   <= RCMD;
            end
            RCMD: begin
               ram_din      <= '0;
               ram_rx_valid <= 1'b0;
               state        <= RWAIT;
`ifdef RAM_ARB_TIMEOUT_EN
               wait_cnt     <= '0;
`endif
            end
            RWAIT: begin
               // data arriving on the timeout cycle still wins
               if (ram_tx_valid) begin
                  rsp_valid <= {own, ~own};
                  rsp_rdata <= ram_dout;
                  rsp_err   <= 1'b0;
                  state     <= RSP;
               end
`ifdef RAM_ARB_TIMEOUT_EN
               else if (wait_cnt == WAIT_LAST) begin
                  rsp_valid <= {own, ~own};
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= RSP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            RSP: begin
               rsp_valid <= 2'b00;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Self-checking bench for ram_cmd_arbiter: directed vector table, corner sequences, randomized traffic vs a timeline model.
// Exercises the read timeout when compiled with RAM_ARB_TIMEOUT_EN.
module tb_ram_cmd_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic [9:0]  ram_din;
   logic        ram_rx_valid;
   logic [7:0]  ram_dout;
   logic        ram_tx_valid;

   int errs = 0;
   int checks = 0;

   ram_cmd_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] rv;
      logic [1:0] we;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] w0;
      logic [7:0] w1;
      logic       tx;
      logic [7:0] dout;
      logic [1:0] e_ready;
      logic [1:0] e_rsp;
      logic [7:0] e_rd;
      logic       e_err;
      logic [9:0] e_din;
      logic       e_rx;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic [1:0] e_ready, input logic [1:0] e_rsp,
                             input logic [7:0] e_rd, input logic e_err, input logic [9:0] e_din, input logic e_rx);
      chk({tag, ".req_ready"},    32'(req_ready),    32'(e_ready));
      chk({tag, ".rsp_valid"},    32'(rsp_valid),    32'(e_rsp));
      chk({tag, ".rsp_rdata"},    32'(rsp_rdata),    32'(e_rd));
      chk({tag, ".rsp_err"},      32'(rsp_err),      32'(e_err));
      chk({tag, ".ram_din"},      32'(ram_din),      32'(e_din));
      chk({tag, ".ram_rx_valid"}, 32'(ram_rx_valid), 32'(e_rx));
   endtask

   task automatic idle_inputs();
      req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
      ram_dout = '0; ram_tx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Read from requester 0; tx_k = cycle offset from grant at which ram_tx_valid is pulsed (-1 = never).
   task automatic run_read(input logic [7:0] addr, input int tx_k, input logic [7:0] dout,
                           output int rsp_k, output logic [7:0] rd, output logic er);
      rsp_k = -1; rd = '0; er = 1'b0;
      @(posedge clk); #1;
      req_valid = 2'b01; req_we = 2'b00; req_addr = {8'h00, addr};
      @(negedge clk);
      chk("read.grant", 32'(req_ready), 32'h1);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         req_valid = 2'b00;
         ram_tx_valid = (k == tx_k);
         ram_dout = (k == tx_k) ? dout : 8'h00;
         @(negedge clk);
         if (rsp_valid != 2'b00 && rsp_k < 0) begin
            rsp_k = k; rd = rsp_rdata; er = rsp_err;
         end
      end
      ram_tx_valid = 1'b0;
   endtask

   // timeline model state for the random phase
   bit         have_txn, busy, last;
   int         t0, end_k, t_d, k;
   bit         t_we, t_own;
   logic [7:0] t_addr, t_wd, t_rd;
   bit         pend[2];
   logic       we_r[2];
   logic [7:0] addr_r[2];
   logic [7:0] wd_r[2];

   initial begin
      int rk;
      logic [7:0] rd;
      logic er;
      int ng, rsp_seen;
      int gc[4];
      logic [1:0] gw[4];
      logic [1:0] e_ready, e_rsp;
      logic [7:0] e_rd;
      logic [9:0] e_din;
      logic e_rx;
      int w;

      vecs[0]  = '{2'b01, 2'b01, 8'h3C, 8'h00, 8'hA5, 8'h00, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
      vecs[1]  = '{2'b00, 2'b00, 8'h99, 8'h00, 8'h11, 8'h00, 1'b1, 8'hFF, 2'b00, 2'b00, 8'h00, 1'b0, 10'h03C, 1'b1};
      vecs[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h1A5, 1'b1};
      vecs[3]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b01, 8'h00, 1'b0, 10'h000, 1'b0};
      vecs[4]  = '{2'b10, 2'b00, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0, 8'h00, 2'b10, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
      vecs[5]  = '{2'b00, 2'b00, 8'h00, 8'hEE, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h23C, 1'b1};
      vecs[6]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h300, 1'b1};
      vecs[7]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
      vecs[8]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hA5, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
      vecs[9]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b10, 8'hA5, 1'b0, 10'h000, 1'b0};
      vecs[10] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h77, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
      vecs[11] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};

      rst = 1'b1;
      idle_inputs();
      #2 check_outs("reset", 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // directed vector table: write from 0, read from 1, spurious tx_valid
      foreach (vecs[i]) begin
         @(posedge clk); #1;
         req_valid = vecs[i].rv; req_we = vecs[i].we;
         req_addr = {vecs[i].a1, vecs[i].a0}; req_wdata = {vecs[i].w1, vecs[i].w0};
         ram_tx_valid = vecs[i].tx; ram_dout = vecs[i].dout;
         @(negedge clk);
         check_outs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_rsp, vecs[i].e_rd,
                    vecs[i].e_err, vecs[i].e_din, vecs[i].e_rx);
      end

      // reset while waiting for read data
      @(posedge clk); #1;
      idle_inputs();
      req_valid = 2'b01; req_addr = {8'h00, 8'h55};
      @(negedge clk);
      chk("rst_mid.grant", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      #2 req_valid = 2'b11; rst = 1'b1;
      #1 check_outs("rst_mid", 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0);
      @(posedge clk); #1 rst = 1'b0; req_valid = 2'b00;
      rsp_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         ram_tx_valid = c[0]; ram_dout = 8'hC3;
         @(negedge clk);
         if (rsp_valid != 2'b00 || ram_rx_valid) rsp_seen++;
      end
      chk("rst_mid.no_rsp", 32'(rsp_seen), 32'h0);
      ram_tx_valid = 1'b0;

      // both requesters hold continuously: grants alternate 0,1,0,1, 4 cycles apart
      @(posedge clk); #1;
      req_valid = 2'b11; req_we = 2'b11; req_addr = 16'hB1A0; req_wdata = 16'hD2C1;
      ng = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin gc[ng] = c; gw[ng] = req_ready; ng++; end
         @(posedge clk); #1;
      end
      chk("rr.count", 32'(ng), 32'h4);
      for (int i = 0; i < ng; i++) begin
         chk($sformatf("rr.who%0d", i), 32'(gw[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("rr.when%0d", i), 32'(gc[i]), 32'(4 * i));
      end
      idle_inputs();
      repeat (4) @(posedge clk);
      #1;

`ifdef RAM_ARB_TIMEOUT_EN
      run_read(8'h11, -1, 8'h00, rk, rd, er);
      chk("timeout.when", 32'(rk), 32'd19);
      chk("timeout.err", 32'(er), 32'h1);
      chk("timeout.rdata", 32'(rd), 32'h0);
      run_read(8'h12, 18, 8'h5A, rk, rd, er);
      chk("tie.when", 32'(rk), 32'd19);
      chk("tie.err", 32'(er), 32'h0);
      chk("tie.rdata", 32'(rd), 32'h5A);
`else
      run_read(8'h11, -1, 8'h00, rk, rd, er);
      chk("no_timeout.stays", 32'(rk), 32'hFFFF_FFFF);
`endif

      // randomized traffic against a cycle-timeline model
      do_reset();
      have_txn = 0; busy = 0; last = 1;
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (busy && (c - t0) >= end_k) busy = 0;
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1; we_r[i] = $urandom_range(0, 1);
               addr_r[i] = 8'($urandom); wd_r[i] = 8'($urandom);
            end
         end
         req_valid = {pend[1], pend[0]};
         req_we = {we_r[1], we_r[0]};
         req_addr = {pend[1] ? addr_r[1] : 8'($urandom), pend[0] ? addr_r[0] : 8'($urandom)};
         req_wdata = {pend[1] ? wd_r[1] : 8'($urandom), pend[0] ? wd_r[0] : 8'($urandom)};
         e_ready = 2'b00; e_rsp = 2'b00; e_rd = 8'h00; e_din = 10'h000; e_rx = 1'b0;
         ram_tx_valid = ($urandom_range(0, 3) == 0); ram_dout = 8'($urandom);
         if (busy) begin
            k = c - t0;
            if (t_we) begin
               if (k == 1) begin e_din = {2'b00, t_addr}; e_rx = 1; end
               if (k == 2) begin e_din = {2'b01, t_wd}; e_rx = 1; end
               if (k == 3) e_rsp = t_own ? 2'b10 : 2'b01;
            end else begin
               if (k == 1) begin e_din = {2'b10, t_addr}; e_rx = 1; end
               if (k == 2) begin e_din = 10'h300; e_rx = 1; end
               if (k >= 3 && k < 3 + t_d) ram_tx_valid = 1'b0;
               if (k == 3 + t_d) begin ram_tx_valid = 1'b1; ram_dout = t_rd; end
               if (k == 4 + t_d) begin e_rsp = t_own ? 2'b10 : 2'b01; e_rd = t_rd; end
            end
         end else if (pend[0] || pend[1]) begin
            w = (pend[0] && pend[1]) ? int'(!last) : (pend[1] ? 1 : 0);
            e_ready = (w == 1) ? 2'b10 : 2'b01;
            have_txn = 1; busy = 1; t0 = c; last = (w == 1);
            t_own = (w == 1); t_we = we_r[w]; t_addr = addr_r[w]; t_wd = wd_r[w];
            t_d = $urandom_range(0, 5); t_rd = 8'($urandom);
            end_k = t_we ? 4 : 5 + t_d;
            pend[w] = 0;
         end
         @(negedge clk);
         check_outs("rand", e_ready, e_rsp, e_rd, 1'b0, e_din, e_rx);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
